// File: rtl/demux_scan_pkg.sv
// Shared types for the demux scan driver: channel geometry, FSM states, next-channel search.
// The search helper is only called when DEMUX_SCAN_SKIP_ZERO_EN is defined.
package demux_scan_pkg;

  localparam int CH_COUNT = 4;
  localparam int SEL_W    = 2;

  typedef enum logic [1:0] {IDLE, SETUP, DRIVE} scan_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] ch;
  } ch_pick_t;

  // Lowest channel at or above 'from' whose bit is set in 'word'.
  function automatic ch_pick_t find_next(input logic [CH_COUNT-1:0] word,
                                         input logic [SEL_W:0]      from);
    ch_pick_t pick;
    pick = '0;
    for (int i = CH_COUNT - 1; i >= 0; i--) begin
      if (word[i] && (i >= int'(from))) begin
        pick.found = 1'b1;
        pick.ch    = SEL_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/demux_scan_driver_if.sv
// Word handshake plus demux-facing outputs of the scan driver.
// slave is the driver side, master is the word source / observer side.
interface demux_scan_driver_if;
  import demux_scan_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [CH_COUNT-1:0] in_data;
  logic                a;
  logic [SEL_W-1:0]    s;
  logic                busy;
  logic                done;

  modport master (output in_valid, in_data,
                  input  in_ready, a, s, busy, done);

  modport slave  (input  in_valid, in_data,
                  output in_ready, a, s, busy, done);

endinterface

// File: rtl/demux_hold_counter.sv
// Per-channel hold timer: clear/enable counter with terminal-count flag on its last cycle.
// tc is combinational from the count register; it only steers next-state logic.
module demux_hold_counter #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // High during the final hold cycle, so the increment on that edge lands exactly on HOLD_CYCLES.
  assign tc = (cnt == CW'(HOLD_CYCLES - 1));

endmodule

// File: rtl/demux_scan_driver.sv
// Plays a 4-bit word onto a 1-to-4 demux one channel per slot; a forced low whenever s may move.
// Fully registered outputs; in_ready only in IDLE. DEMUX_SCAN_SKIP_ZERO_EN skips zero-bit channels.
module demux_scan_driver
  import demux_scan_pkg::*;
#(
  parameter int HOLD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  demux_scan_driver_if.slave  bus
);

  scan_state_t         state, state_nxt;
  logic [CH_COUNT-1:0] word;
  logic [SEL_W-1:0]    ch_nxt;
  logic                accept;
  logic                finish;
  logic                hold_tc;

  logic                a_q, ready_q, busy_q, done_q;
  logic [SEL_W-1:0]    s_q;
  logic                a_nxt;
  logic [SEL_W-1:0]    s_nxt;

  assign accept = (state == IDLE) && bus.in_valid;

  demux_hold_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk (clk),
    .rst (rst),
    .clr (state != DRIVE),
    .en  (state == DRIVE),
    .tc  (hold_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ch_nxt    = s_q;
    finish    = 1'b0;
`ifdef DEMUX_SCAN_SKIP_ZERO_EN
    begin : skip_search
      ch_pick_t pick;
      pick = '0;
      case (state)
        IDLE: begin
          if (accept) begin
            pick = find_next(bus.in_data, '0);
            if (pick.found) begin
              state_nxt = SETUP;
              ch_nxt    = pick.ch;
            end else begin
              finish = 1'b1;
            end
          end
        end
        SETUP: state_nxt = DRIVE;
        DRIVE: begin
          if (hold_tc) begin
            pick = find_next(word, {1'b0, s_q} + 1'b1);
            if (pick.found) begin
              state_nxt = SETUP;
              ch_nxt    = pick.ch;
            end else begin
              state_nxt = IDLE;
              finish    = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
`else
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          ch_nxt    = '0;
        end
      end
      SETUP: state_nxt = DRIVE;
      DRIVE: begin
        if (hold_tc) begin
          if (s_q == SEL_W'(CH_COUNT - 1)) begin
            state_nxt = IDLE;
            finish    = 1'b1;
          end else begin
            state_nxt = SETUP;
            ch_nxt    = s_q + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
`endif
  end

  // Select only moves on the edge into SETUP, where a is forced low.
  always_comb begin
    a_nxt = 1'b0;
    s_nxt = s_q;
    if (state_nxt == DRIVE) begin
      a_nxt = word[s_q];
    end
    if (state_nxt == SETUP) begin
      s_nxt = ch_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= 1'b0;
      s_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      word    <= '0;
    end else begin
      a_q     <= a_nxt;
      s_q     <= s_nxt;
      ready_q <= (state_nxt == IDLE);
      busy_q  <= (state_nxt != IDLE);
      done_q  <= finish;
      if (accept) begin
        word <= bus.in_data;
      end
    end
  end

  assign bus.a        = a_q;
  assign bus.s        = s_q;
  assign bus.in_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
